// File: rtl/code_entry_sequencer.sv
// -----------------------------------------------------------------------------
// code_entry_sequencer
//
// Keypad-side front end for the four-digit combination lock. Collects 3-bit
// digits one per strobe into a 12-bit code, issues one-cycle save/check strobes
// to the lock core, waits for the core's verdict, counts consecutive failed
// checks and enforces a timed lockout after MAX_TRIES failures.
//
// Optional feature: define ENTRY_TIMEOUT_EN to discard a partial entry after
// TIMEOUT_CYCLES idle cycles. Without it, partial entries persist until
// key_clear, a strobe or reset.
//
// Parameters
//   MAX_TRIES       consecutive failed checks that trigger lockout (1..7)
//   LOCK_CYCLES     lockout duration in clk cycles (>= 1)
//   TIMEOUT_CYCLES  idle cycles before a partial entry is discarded
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   key_valid     one-cycle digit strobe, key_digit sampled with it
//   key_digit     3-bit digit value
//   key_clear     discard the current entry
//   key_save      program the entered code (needs four digits)
//   key_check     test the entered code (needs four digits)
//   result_valid  lock core verdict strobe (only honoured in WAIT)
//   result_match  verdict: 1 = code matched
//   code          assembled code, first digit in [2:0], fourth in [11:9]
//   count         digits entered, 0..4
//   save_stb      one-cycle program strobe to the lock core
//   check_stb     one-cycle compare strobe to the lock core
//   fail_cnt      consecutive failed checks
//   locked        lockout active
//   busy          high in STROBE, WAIT and LOCKED
// -----------------------------------------------------------------------------
module code_entry_sequencer #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [2:0]  key_digit,
  input  logic        key_clear,
  input  logic        key_save,
  input  logic        key_check,
  input  logic        result_valid,
  input  logic        result_match,
  output logic [11:0] code,
  output logic [2:0]  count,
  output logic        save_stb,
  output logic        check_stb,
  output logic [2:0]  fail_cnt,
  output logic        locked,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Timer holds LOCK_CYCLES-1 down to 0, so clog2(LOCK_CYCLES) bits suffice.
  localparam int unsigned TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [3:0]    MAX_TRIES_W = 4'(MAX_TRIES);

  state_t        state_q, state_d;
  logic          is_check_q, is_check_d;   // strobe type latched for STROBE
  logic [11:0]   code_q, code_d;
  logic [2:0]    count_q, count_d;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;

`ifdef ENTRY_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    is_check_d = is_check_q;
    code_d     = code_q;
    count_d    = count_q;
    fail_d     = fail_q;
    timer_d    = timer_q;

    unique case (state_q)
      ST_ENTRY: begin
        // One request per cycle: clear > save > check > digit.
        if (key_clear) begin
          code_d  = '0;
          count_d = '0;
        end else if (key_save && count_q == 3'd4) begin
          state_d    = ST_STROBE;
          is_check_d = 1'b0;
        end else if (key_check && count_q == 3'd4) begin
          state_d    = ST_STROBE;
          is_check_d = 1'b1;
        end else if (key_valid && count_q != 3'd4) begin
          code_d[3*int'(count_q[1:0]) +: 3] = key_digit;
          count_d = count_q + 3'd1;
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (!key_valid && count_q != 3'd0 && idle_q == IDLE_LAST) begin
          code_d  = '0;
          count_d = '0;
        end
`endif
      end

      ST_STROBE: begin
        if (is_check_q) begin
          state_d = ST_WAIT;          // code stays held for the compare
        end else begin
          state_d = ST_ENTRY;
          code_d  = '0;
          count_d = '0;
        end
      end

      ST_WAIT: begin
        if (result_valid) begin
          code_d  = '0;
          count_d = '0;
          if (result_match) begin
            fail_d  = '0;
            state_d = ST_ENTRY;
          end else if (({1'b0, fail_q} + 4'd1) < MAX_TRIES_W) begin
            fail_d  = fail_q + 3'd1;
            state_d = ST_ENTRY;
          end else begin
            fail_d  = MAX_TRIES_W[2:0];
            timer_d = LOCK_LOAD;
            state_d = ST_LOCKED;
          end
        end
      end

      ST_LOCKED: begin
        // Entered with LOCK_CYCLES-1 and left after the cycle at 0, so locked
        // is high for exactly LOCK_CYCLES cycles.
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = ST_ENTRY;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

`ifdef ENTRY_TIMEOUT_EN
  // Idle counter runs only while a partial entry sits in ENTRY; any key_valid,
  // an empty entry, a timeout clear or leaving ENTRY returns it to 0.
  always_comb begin
    idle_d = '0;
    if (state_q == ST_ENTRY && state_d == ST_ENTRY &&
        count_d != 3'd0 && !key_valid) begin
      idle_d = idle_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ENTRY;
      is_check_q <= 1'b0;
      code_q     <= '0;
      count_q    <= '0;
      fail_q     <= '0;
      timer_q    <= '0;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      is_check_q <= is_check_d;
      code_q     <= code_d;
      count_q    <= count_d;
      fail_q     <= fail_d;
      timer_q    <= timer_d;
`ifdef ENTRY_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state, so they are glitch-free per cycle.
  // ---------------------------------------------------------------------------
  assign code      = code_q;
  assign count     = count_q;
  assign fail_cnt  = fail_q;
  assign save_stb  = (state_q == ST_STROBE) && !is_check_q;
  assign check_stb = (state_q == ST_STROBE) &&  is_check_q;
  assign locked    = (state_q == ST_LOCKED);
  assign busy      = (state_q != ST_ENTRY);

endmodule

// File: tb/tb_code_entry_sequencer.sv
// -----------------------------------------------------------------------------
// tb_code_entry_sequencer
//
// Self-checking bench for code_entry_sequencer. Expected strobes (type and
// code) are queued when save/check is requested; a negedge monitor pops and
// compares them whenever the DUT raises save_stb or check_stb. Other outputs
// are checked directly one time unit after the active edge.
// -----------------------------------------------------------------------------
module tb_code_entry_sequencer;

  localparam int LOCK = 1000;
  localparam int TO   = 10;
  localparam int MAXT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, key_clear, key_save, key_check;
  logic [2:0]  key_digit;
  logic        result_valid, result_match;
  logic [11:0] code;
  logic [2:0]  count, fail_cnt;
  logic        save_stb, check_stb, locked, busy;

  code_entry_sequencer #(
    .MAX_TRIES      (MAXT),
    .LOCK_CYCLES    (LOCK),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_clear    (key_clear),
    .key_save     (key_save),
    .key_check    (key_check),
    .result_valid (result_valid),
    .result_match (result_match),
    .code         (code),
    .count        (count),
    .save_stb     (save_stb),
    .check_stb    (check_stb),
    .fail_cnt     (fail_cnt),
    .locked       (locked),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // {save, check}
    logic [11:0] code;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor / scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (save_stb || check_stb)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, save_stb, check_stb}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {30'd0, save_stb, check_stb}, {30'd0, e.kind});
        check("strobe_code", {20'd0, code}, {20'd0, e.code});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    key_valid = 0; key_clear = 0; key_save = 0; key_check = 0;
    key_digit = 0; result_valid = 0; result_match = 0;
  endtask

  task automatic digit(input logic [2:0] d);
    key_valid = 1; key_digit = d;
    cyc();
    key_valid = 0;
  endtask

  task automatic enter4(input logic [11:0] c);
    for (int i = 0; i < 4; i++) digit(c[3*i +: 3]);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {10'd0, code, count, save_stb, check_stb, fail_cnt, locked, busy},
          32'd0);
  endtask

  task automatic do_save(input logic [11:0] c);
    sb.push_back({2'b10, c});
    key_save = 1;
    cyc();
    key_save = 0;
    check("save_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("save_code_clr", {20'd0, code}, 32'd0);
    check("save_count_clr", {29'd0, count}, 32'd0);
    check("save_busy_clr", {31'd0, busy}, 32'd0);
  endtask

  // Check request, hold in WAIT for wait_n cycles while keys are hammered,
  // then deliver the verdict.
  task automatic do_check(input logic [11:0] c, input logic match,
                          input int wait_n);
    sb.push_back({2'b01, c});
    key_check = 1;
    cyc();
    key_check = 0;
    cyc();
    check("wait_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < wait_n; i++) begin
      key_clear = 1; key_valid = 1; key_digit = 3'd7; key_save = 1;
      cyc();
      check("wait_code_hold", {20'd0, code}, {20'd0, c});
    end
    idle_inputs();
    result_valid = 1; result_match = match;
    cyc();
    result_valid = 0; result_match = 0;
    check("verdict_code_clr", {20'd0, code}, 32'd0);
    check("verdict_count_clr", {29'd0, count}, 32'd0);
  endtask

  task automatic fail_to_lock();
    logic [11:0] c;
    for (int i = 1; i <= MAXT; i++) begin
      c = 12'($urandom);
      enter4(c);
      do_check(c, 1'b0, 1);
      check("fail_cnt_step", {29'd0, fail_cnt}, i);
      check("locked_step", {31'd0, locked}, (i == MAXT) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1;
    cyc(3);
    check_zero("reset_outputs");
    rst = 0;

    // Verdict outside WAIT is ignored.
    result_valid = 1; result_match = 0;
    cyc();
    idle_inputs();
    check("stray_verdict_fail", {29'd0, fail_cnt}, 32'd0);
    check("stray_verdict_busy", {31'd0, busy}, 32'd0);

    // Save path: digits 5,2,7,1.
    enter4(12'o1725);
    check("entry_code", {20'd0, code}, 32'o1725);
    check("entry_count", {29'd0, count}, 32'd4);
    do_save(12'o1725);

    // Check path with a match.
    enter4(12'o1725);
    do_check(12'o1725, 1'b1, 3);
    check("match_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    check("match_busy", {31'd0, busy}, 32'd0);

    // One failure, then a match clears the failure count.
    enter4(12'o3344);
    do_check(12'o3344, 1'b0, 0);
    check("one_fail", {29'd0, fail_cnt}, 32'd1);
    enter4(12'o0017);
    do_check(12'o0017, 1'b1, 0);
    check("fail_reset_by_match", {29'd0, fail_cnt}, 32'd0);

    // Lockout: count cycles with locked high while throwing keys at it.
    fail_to_lock();
    n = 0;
    while (locked && n < LOCK + 10) begin
      n++;
      key_valid = 1'($urandom); key_digit = 3'($urandom);
      key_save = 1'($urandom); key_check = 1'($urandom);
      result_valid = 1'($urandom); result_match = 1'($urandom);
      cyc();
    end
    idle_inputs();
    check("lock_length", n, LOCK);
    check("post_lock_fail", {29'd0, fail_cnt}, 32'd0);
    check("post_lock_count", {29'd0, count}, 32'd0);
    check("post_lock_busy", {31'd0, busy}, 32'd0);

    // Boundaries.
    digit(3'd1); digit(3'd2); digit(3'd3);
    key_check = 1; key_save = 1;
    cyc();
    idle_inputs();
    check("short_req_count", {29'd0, count}, 32'd3);
    check("short_req_busy", {31'd0, busy}, 32'd0);
    digit(3'd4);
    digit(3'd7);
    check("fifth_digit_code", {20'd0, code}, 32'o4321);
    check("fifth_digit_count", {29'd0, count}, 32'd4);
    key_clear = 1; key_save = 1;
    cyc();
    idle_inputs();
    check("clear_vs_save_code", {20'd0, code}, 32'd0);
    check("clear_vs_save_count", {29'd0, count}, 32'd0);
    cyc();
    check("clear_vs_save_busy", {31'd0, busy}, 32'd0);
    digit(3'd5);
    key_clear = 1; key_valid = 1; key_digit = 3'd6;
    cyc();
    idle_inputs();
    check("clear_vs_digit", {29'd0, count}, 32'd0);

    // Reset during WAIT.
    enter4(12'o7654);
    sb.push_back({2'b01, 12'o7654});
    key_check = 1;
    cyc();
    key_check = 0;
    cyc();
    check("pre_rst_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1;
    cyc();
    check_zero("rst_in_wait");
    rst = 0;
    digit(3'd6);
    check("after_rst_entry_count", {29'd0, count}, 32'd1);
    check("after_rst_entry_code", {20'd0, code}, 32'd6);
    key_clear = 1;
    cyc();
    idle_inputs();

    // Reset mid-lockout.
    fail_to_lock();
    cyc(100);
    check("mid_lock_locked", {31'd0, locked}, 32'd1);
    rst = 1;
    cyc();
    check_zero("rst_in_locked");
    rst = 0;
    cyc();
    check("after_rst_lock_busy", {31'd0, busy}, 32'd0);

    // Partial-entry timeout.
    digit(3'd2); digit(3'd3);
`ifdef ENTRY_TIMEOUT_EN
    cyc(TO - 1);
    check("timeout_before", {29'd0, count}, 32'd2);
    cyc();
    check("timeout_count", {29'd0, count}, 32'd0);
    check("timeout_code", {20'd0, code}, 32'd0);
`else
    cyc(2 * TO);
    check("no_timeout_count", {29'd0, count}, 32'd2);
    check("no_timeout_code", {20'd0, code}, 32'o32);
`endif

    cyc(2);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
